// File: rtl/reg_univ_if.sv
// Bus bundle for reg_univ: operation controls, load/serial data and status outputs.
// Clock and reset stay plain ports on the register itself.
interface reg_univ_if #(
  parameter int WIDTH = 3
);
  logic             es;
  logic             eena;
  logic [2:0]       emode;
  logic [WIDTH-1:0] ed;
  logic             esil;
  logic             esir;
  logic [WIDTH-1:0] sq;
  logic             sso;
  logic             stc;
  logic             sovf;

  modport master (
    output es, eena, emode, ed, esil, esir,
    input  sq, sso, stc, sovf
  );

  modport slave (
    input  es, eena, emode, ed, esil, esir,
    output sq, sso, stc, sovf
  );
endinterface

// File: rtl/reg_univ.sv
// Parametrised universal register: hold, load, shift, rotate and up/down count,
// with serial-out, combinational terminal count and a sticky wrap flag.
module reg_univ #(
  parameter int             WIDTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL   = {WIDTH{1'b1}}
) (
  input  logic       eck,
  input  logic       er,
  reg_univ_if.slave  bus
);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_UP   = 3'b110;
  localparam logic [2:0] M_DN   = 3'b111;

  localparam logic [WIDTH-1:0] ONE_V  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_V = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_V = {WIDTH{1'b0}};

  logic [WIDTH-1:0] q_r;
  logic             sso_r;
  logic             ovf_r;

  logic [WIDTH-1:0] q_nxt_s;
  logic             sso_nxt_s;
  logic             ovf_nxt_s;
  logic             ones_s;
  logic             zero_s;

  assign ones_s = (q_r == ONES_V);
  assign zero_s = (q_r == ZERO_V);

  // Next-state selection for set, enable gating and the eight modes.
  always_comb begin
    q_nxt_s   = q_r;
    sso_nxt_s = sso_r;
    ovf_nxt_s = ovf_r;
    if (bus.es) begin
      q_nxt_s   = SET_VAL;
      sso_nxt_s = 1'b0;
      ovf_nxt_s = 1'b0;
    end else if (!bus.eena) begin
      q_nxt_s   = q_r;
      sso_nxt_s = sso_r;
      ovf_nxt_s = ovf_r;
    end else begin
      case (bus.emode)
        M_HOLD: begin
          q_nxt_s = q_r;
        end
        M_LOAD: begin
          q_nxt_s   = bus.ed;
          ovf_nxt_s = 1'b0;
        end
        M_SHL: begin
          q_nxt_s   = {q_r[WIDTH-2:0], bus.esil};
          sso_nxt_s = q_r[WIDTH-1];
        end
        M_SHR: begin
          q_nxt_s   = {bus.esir, q_r[WIDTH-1:1]};
          sso_nxt_s = q_r[0];
        end
        M_ROL: begin
          q_nxt_s   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
          sso_nxt_s = q_r[WIDTH-1];
        end
        M_ROR: begin
          q_nxt_s   = {q_r[0], q_r[WIDTH-1:1]};
          sso_nxt_s = q_r[0];
        end
        M_UP: begin
          q_nxt_s   = q_r + ONE_V;
          ovf_nxt_s = ovf_r | ones_s;
        end
        M_DN: begin
          q_nxt_s   = q_r - ONE_V;
          ovf_nxt_s = ovf_r | zero_s;
        end
        default: begin
          q_nxt_s = q_r;
        end
      endcase
    end
  end

  // State register; er overrides everything else on the edge.
  always_ff @(posedge eck) begin
    if (er) begin
      q_r   <= RESET_VAL;
      sso_r <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      q_r   <= q_nxt_s;
      sso_r <= sso_nxt_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  // stc is deliberately combinational so it can feed the eena of a cascaded stage.
  assign bus.stc  = bus.eena & (((bus.emode == M_UP) & ones_s) | ((bus.emode == M_DN) & zero_s));
  assign bus.sq   = q_r;
  assign bus.sso  = sso_r;
  assign bus.sovf = ovf_r;

endmodule

// File: tb/tb_reg_univ.sv
// Self-checking bench for reg_univ: directed vector table on a 3-bit instance,
// hand sequences for reset/wrap corners, and randomized runs against an arithmetic model.
module tb_reg_univ;

  logic eck = 1'b0;
  logic er3 = 1'b0;
  logic er8 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 eck = ~eck;

  reg_univ_if #(.WIDTH(3)) b3 ();
  reg_univ_if #(.WIDTH(8)) b8 ();

  reg_univ #(.WIDTH(3)) u3 (.eck(eck), .er(er3), .bus(b3.slave));
  reg_univ #(.WIDTH(8), .RESET_VAL(8'h5A)) u8 (.eck(eck), .er(er8), .bus(b8.slave));

  typedef struct {
    logic       er;
    logic       es;
    logic       ena;
    logic [2:0] mode;
    logic [2:0] d;
    logic       sil;
    logic       sir;
    logic       estc;
    logic [2:0] eq;
    logic       esso;
    logic       eovf;
  } vec_t;

  typedef struct {
    int q;
    int sso;
    int ovf;
  } st_t;

  vec_t vec [18];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model from the mode rules, using plain integer arithmetic.
  function automatic st_t model(input st_t s, input int w, input bit r, input bit st,
                                input bit ena, input int mode, input int d, input bit sil,
                                input bit sir, input int rv, input int sv);
    st_t n = s;
    int m = 1 << w;
    int top = 1 << (w - 1);
    if (r) begin
      n.q = rv; n.sso = 0; n.ovf = 0;
    end else if (st) begin
      n.q = sv; n.sso = 0; n.ovf = 0;
    end else if (ena) begin
      case (mode)
        1: begin n.q = d % m; n.ovf = 0; end
        2: begin n.q = (s.q * 2 + int'(sil)) % m; n.sso = s.q / top; end
        3: begin n.q = s.q / 2 + (sir ? top : 0); n.sso = s.q % 2; end
        4: begin n.q = (s.q * 2) % m + s.q / top; n.sso = s.q / top; end
        5: begin n.q = s.q / 2 + ((s.q % 2) * top); n.sso = s.q % 2; end
        6: begin n.q = (s.q + 1) % m; if (s.q == m - 1) n.ovf = 1; end
        7: begin n.q = (s.q + m - 1) % m; if (s.q == 0) n.ovf = 1; end
        default: n = s;
      endcase
    end
    return n;
  endfunction

  function automatic int model_stc(input st_t s, input int w, input bit ena, input int mode);
    int m = 1 << w;
    return int'(ena && ((mode == 6 && s.q == m - 1) || (mode == 7 && s.q == 0)));
  endfunction

  task automatic drive3(input logic r, input logic st, input logic ena, input logic [2:0] mode,
                        input logic [2:0] d, input logic sil, input logic sir);
    er3 = r; b3.es = st; b3.eena = ena; b3.emode = mode; b3.ed = d; b3.esil = sil; b3.esir = sir;
  endtask

  task automatic edge_wait();
    @(posedge eck);
    #1;
  endtask

  st_t s3, s8, n3, n8;

  initial begin
    drive3(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0);
    er8 = 1'b0; b8.es = 1'b0; b8.eena = 1'b0; b8.emode = 3'd0; b8.ed = 8'd0;
    b8.esil = 1'b0; b8.esir = 1'b0;

    //           er    es    ena   mode    d       sil   sir   stc   q       sso   ovf
    vec[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[1]  = '{1'b1, 1'b1, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 1'b1, 3'd1, 3'd5, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0};
    vec[6]  = '{1'b0, 1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 1'b1, 3'd3, 3'd0, 1'b0, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 1'b1, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 1'b1, 3'd5, 3'd0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vec[10] = '{1'b0, 1'b0, 1'b1, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1, 1'b0};
    vec[11] = '{1'b0, 1'b0, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b1, 1'b0};
    vec[12] = '{1'b0, 1'b0, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 1'b1};
    vec[13] = '{1'b0, 1'b0, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1};
    vec[14] = '{1'b0, 1'b0, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1};
    vec[15] = '{1'b0, 1'b0, 1'b1, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0};
    vec[16] = '{1'b0, 1'b0, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b1, 1'b1};
    vec[17] = '{1'b0, 1'b1, 1'b1, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 3'd7, 1'b0, 1'b0};

    #1;
    for (int i = 0; i < 18; i++) begin
      drive3(vec[i].er, vec[i].es, vec[i].ena, vec[i].mode, vec[i].d, vec[i].sil, vec[i].sir);
      #1;
      chk($sformatf("vec%0d_stc", i), int'(b3.stc), int'(vec[i].estc));
      edge_wait();
      chk($sformatf("vec%0d_sq", i), int'(b3.sq), int'(vec[i].eq));
      chk($sformatf("vec%0d_sso", i), int'(b3.sso), int'(vec[i].esso));
      chk($sformatf("vec%0d_sovf", i), int'(b3.sovf), int'(vec[i].eovf));
    end

    // Reset in the middle of a count, then resume from the reset value.
    drive3(1'b0, 1'b0, 1'b1, 3'd6, 3'd0, 1'b0, 1'b0);
    edge_wait();
    chk("mid_wrap_sq", int'(b3.sq), 0);
    chk("mid_wrap_ovf", int'(b3.sovf), 1);
    edge_wait();
    chk("mid_cnt_sq", int'(b3.sq), 1);
    er3 = 1'b1;
    edge_wait();
    chk("mid_rst_sq", int'(b3.sq), 0);
    chk("mid_rst_ovf", int'(b3.sovf), 0);
    er3 = 1'b0;
    edge_wait();
    chk("resume_sq", int'(b3.sq), 1);
    chk("resume_ovf", int'(b3.sovf), 0);

    // Wide instance: custom reset value and a long up-count with wraps.
    er8 = 1'b1;
    edge_wait();
    chk("w8_rst_sq", int'(b8.sq), 'h5A);
    er8 = 1'b0; b8.eena = 1'b1; b8.emode = 3'd6;
    for (int i = 0; i < 300; i++) edge_wait();
    chk("w8_cnt300_sq", int'(b8.sq), 'h86);
    chk("w8_cnt300_ovf", int'(b8.sovf), 1);
    b8.es = 1'b1;
    edge_wait();
    chk("w8_set_sq", int'(b8.sq), 'hFF);
    chk("w8_set_ovf", int'(b8.sovf), 0);
    b8.es = 1'b0;

    // Randomized traffic on both instances against the model.
    s3 = '{0, 0, 0};
    s8 = '{0, 0, 0};
    for (int i = 0; i < 400; i++) begin
      er3 = (i == 0) || ($urandom_range(0, 29) == 0);
      b3.es = ($urandom_range(0, 29) == 0);
      b3.eena = ($urandom_range(0, 4) != 0);
      b3.emode = 3'($urandom_range(0, 7));
      b3.ed = 3'($urandom);
      b3.esil = 1'($urandom);
      b3.esir = 1'($urandom);
      er8 = (i == 0) || ($urandom_range(0, 29) == 0);
      b8.es = ($urandom_range(0, 29) == 0);
      b8.eena = ($urandom_range(0, 4) != 0);
      b8.emode = 3'($urandom_range(0, 7));
      b8.ed = (i % 7 == 0) ? 8'hFF : 8'($urandom);
      b8.esil = 1'($urandom);
      b8.esir = 1'($urandom);
      #1;
      if (i > 0) begin
        chk("rnd3_stc", int'(b3.stc), model_stc(s3, 3, b3.eena, int'(b3.emode)));
        chk("rnd8_stc", int'(b8.stc), model_stc(s8, 8, b8.eena, int'(b8.emode)));
      end
      n3 = model(s3, 3, er3, b3.es, b3.eena, int'(b3.emode), int'(b3.ed), b3.esil, b3.esir, 0, 7);
      n8 = model(s8, 8, er8, b8.es, b8.eena, int'(b8.emode), int'(b8.ed), b8.esil, b8.esir,
                 'h5A, 'hFF);
      edge_wait();
      s3 = n3;
      s8 = n8;
      chk("rnd3_sq", int'(b3.sq), s3.q);
      chk("rnd3_sso", int'(b3.sso), s3.sso);
      chk("rnd3_sovf", int'(b3.sovf), s3.ovf);
      chk("rnd8_sq", int'(b8.sq), s8.q);
      chk("rnd8_sso", int'(b8.sso), s8.sso);
      chk("rnd8_sovf", int'(b8.sovf), s8.ovf);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
